// File: rtl/lu_address_gen_pkg.sv
// Shared types and default widths for the lock-in reference address generator.
package lockin_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int B_DEPTH_DEFAULT   = 14;
    localparam int B_ACC_DEFAULT     = 32;
    localparam int B_PERIODS_DEFAULT = 16;

endpackage

// File: rtl/lu_address_gen_if.sv
// Control/config/output bundle between a frame controller and the address generator.
interface lu_address_gen_if #(
    parameter int B_depth_lu_table = 14,
    parameter int B_acc            = 32,
    parameter int B_periods        = 16
);
    logic                        start;
    logic                        stop;
    logic [B_acc-1:0]            freq_word;
    logic [B_depth_lu_table-1:0] phase_offset;
    logic [B_periods-1:0]        n_periods;
    logic [B_depth_lu_table-1:0] address;
    logic                        address_valid;
    logic                        period_tick;
    logic                        frame_done;
    logic                        busy;

    modport master (
        output start, stop, freq_word, phase_offset, n_periods,
        input  address, address_valid, period_tick, frame_done, busy
    );

    modport slave (
        input  start, stop, freq_word, phase_offset, n_periods,
        output address, address_valid, period_tick, frame_done, busy
    );
endinterface

// File: rtl/lu_address_gen_phase_accumulator.sv
// Phase accumulator with registered wrap carry; exposes only the top phase bits.
module phase_accumulator #(
    parameter int B_acc = 32,
    parameter int B_out = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [B_acc-1:0] i_fw,
    output logic [B_out-1:0] o_phase,
    output logic             o_carry
);
    logic [B_acc-1:0] r_acc;
    logic             r_carry;

    // r_carry flags that the value now held in r_acc was produced by a wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_carry <= 1'b0;
        end else if (i_load) begin
            r_acc   <= i_fw;
            r_carry <= 1'b0;
        end else if (i_en) begin
            {r_carry, r_acc} <= {1'b0, r_acc} + {1'b0, i_fw};
        end
    end

    assign o_phase = r_acc[B_acc-1 -: B_out];
    assign o_carry = r_carry;
endmodule

// File: rtl/lu_address_gen.sv
// NCO address generator for the sin/cos table: frame FSM, period counting and offset add.
module lu_address_gen
    import lockin_pkg::*;
#(
    parameter int B_depth_lu_table = B_DEPTH_DEFAULT,
    parameter int B_acc            = B_ACC_DEFAULT,
    parameter int B_periods        = B_PERIODS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    lu_address_gen_if.slave bus
);
    state_t                      r_state;
    state_t                      w_state_nxt;
    logic                        w_load;
    logic                        w_run_step;
    logic [B_acc-1:0]            r_fw;
    logic [B_acc-1:0]            w_fw;
    logic [B_depth_lu_table-1:0] r_offset;
    logic [B_periods-1:0]        r_nper;
    logic [B_periods-1:0]        r_cnt;
    logic [B_periods-1:0]        w_cnt_inc;
    logic [B_depth_lu_table-1:0] w_phase;
    logic                        w_carry;
    logic                        w_done_hit;
    logic [B_depth_lu_table-1:0] r_address;
    logic                        r_period_tick;
    logic                        r_frame_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Exit cycles (stop or completed frame) do not advance: address keeps the last sample
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_run_step  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (bus.stop || r_frame_done) w_state_nxt = IDLE;
                else                          w_run_step  = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fw     <= '0;
            r_offset <= '0;
            r_nper   <= '0;
        end else if (w_load) begin
            r_fw     <= bus.freq_word;
            r_offset <= bus.phase_offset;
            r_nper   <= bus.n_periods;
        end
    end

    assign w_fw = w_load ? bus.freq_word : r_fw;

    phase_accumulator #(
        .B_acc (B_acc),
        .B_out (B_depth_lu_table)
    ) u_phase_acc (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_load  (w_load),
        .i_en    (w_run_step),
        .i_fw    (w_fw),
        .o_phase (w_phase),
        .o_carry (w_carry)
    );

    assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    assign w_done_hit = w_carry && (r_nper != '0) && (w_cnt_inc == r_nper);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_address     <= '0;
            r_cnt         <= '0;
            r_period_tick <= 1'b0;
            r_frame_done  <= 1'b0;
        end else if (w_load) begin
            r_address     <= bus.phase_offset;
            r_cnt         <= '0;
            r_period_tick <= 1'b0;
            r_frame_done  <= 1'b0;
        end else if (w_run_step) begin
            r_address     <= w_phase + r_offset;
            r_period_tick <= w_carry;
            r_frame_done  <= w_done_hit;
            if (w_carry) r_cnt <= w_cnt_inc;
        end else begin
            r_period_tick <= 1'b0;
            r_frame_done  <= 1'b0;
        end
    end

    assign bus.address       = r_address;
    assign bus.address_valid = (r_state == RUN);
    assign bus.busy          = (r_state == RUN);
    assign bus.period_tick   = r_period_tick;
    assign bus.frame_done    = r_frame_done;
endmodule

// File: tb/tb_lu_address_gen.sv
// Directed plus randomized frames checked against an arithmetic NCO model.
module tb_lu_address_gen;
    localparam int AW = 14;
    localparam int PW = 32;
    localparam int NW = 16;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_err;

    lu_address_gen_if #(.B_depth_lu_table(AW), .B_acc(PW), .B_periods(NW)) bus ();

    lu_address_gen #(.B_depth_lu_table(AW), .B_acc(PW), .B_periods(NW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: sample i sits at phase i*fw; a wrap happened if the integer turn count grew
    function automatic logic [AW-1:0] model_addr(input longint unsigned i, input logic [PW-1:0] fw,
                                                 input logic [AW-1:0] off);
        longint unsigned ph;
        ph = (i * longint'(fw)) % (64'd1 << PW);
        return AW'((ph >> (PW - AW)) + longint'(off));
    endfunction

    function automatic longint unsigned turns(input longint unsigned i, input logic [PW-1:0] fw);
        return (i * longint'(fw)) >> PW;
    endfunction

    task automatic check_idle(input string tag, input logic [AW-1:0] addr);
        check({tag, "_valid"}, bus.address_valid, 0);
        check({tag, "_busy"},  bus.busy, 0);
        check({tag, "_tick"},  bus.period_tick, 0);
        check({tag, "_done"},  bus.frame_done, 0);
        check({tag, "_addr"},  bus.address, addr);
    endtask

    task automatic run_frame(input string tag, input logic [PW-1:0] fw, input logic [AW-1:0] off,
                             input logic [NW-1:0] np, input int stop_at, input int restart_at,
                             input int limit);
        int              ticks;
        logic [AW-1:0]   exp_a;
        bit              etick;
        bit              edone;
        bus.freq_word    = fw;
        bus.phase_offset = off;
        bus.n_periods    = np;
        bus.start        = 1'b1;
        step();
        bus.start        = 1'b0;
        bus.freq_word    = $urandom;
        bus.phase_offset = AW'($urandom);
        bus.n_periods    = NW'($urandom);
        ticks = 0;
        for (int i = 0; i <= limit; i++) begin
            if (i == limit) begin
                check({tag, "_bound"}, bus.busy, 0);
                bus.stop = 1'b1;
                step();
                bus.stop = 1'b0;
                break;
            end
            etick = (i > 0) && (turns(i, fw) != turns(i - 1, fw));
            if (etick && ticks != (1 << NW) - 1) ticks++;
            edone = etick && (np != 0) && (ticks == int'(np));
            exp_a = model_addr(i, fw, off);
            check({tag, "_valid"}, bus.address_valid, 1);
            check({tag, "_busy"},  bus.busy, 1);
            check({tag, "_addr"},  bus.address, exp_a);
            check({tag, "_tick"},  bus.period_tick, etick);
            check({tag, "_done"},  bus.frame_done, edone);
            if (i == restart_at) begin
                bus.start     = 1'b1;
                bus.freq_word = $urandom;
            end
            if (i == stop_at) bus.stop = 1'b1;
            step();
            bus.start = 1'b0;
            bus.stop  = 1'b0;
            if (edone || i == stop_at) begin
                check_idle({tag, "_end"}, exp_a);
                step();
                check_idle({tag, "_hold"}, exp_a);
                break;
            end
        end
    endtask

    initial begin
        logic [PW-1:0] rfw;
        n_checks         = 0;
        n_err            = 0;
        reset_n          = 1'b0;
        bus.start        = 1'b0;
        bus.stop         = 1'b0;
        bus.freq_word    = '0;
        bus.phase_offset = '0;
        bus.n_periods    = '0;
        step();
        step();
        check_idle("reset", 0);
        reset_n = 1'b1;
        step();
        check_idle("post_reset", 0);

        run_frame("sweep", 32'h1000_0000, 14'd0, 16'd2, -1, -1, 60);
        run_frame("offwrap", 32'h1000_0000, 14'd16000, 16'd1, -1, -1, 40);
        run_frame("abort", 32'h4000_0000, 14'd0, 16'd0, 10, -1, 30);

        bus.start = 1'b1;
        bus.stop  = 1'b1;
        step();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check("contend_busy", bus.busy, 0);
        step();
        check("contend_busy2", bus.busy, 0);
        check("contend_valid", bus.address_valid, 0);

        run_frame("restart", 32'h1000_0000, 14'd3, 16'd1, -1, 3, 40);
        run_frame("fw0", 32'h0, 14'd5, 16'd1, 20, -1, 40);

        for (int k = 0; k < 4; k++) begin
            rfw = $urandom_range(32'hFFFF_FFFF, 32'h0400_0000);
            run_frame("rand", rfw, AW'($urandom), NW'($urandom_range(5, 1)), -1, -1, 400);
        end
        rfw = $urandom_range(32'hFFFF_FFFF, 32'h0100_0000);
        run_frame("rand_free", rfw, AW'($urandom), 16'd0, int'($urandom_range(40, 5)), -1, 60);

        bus.freq_word    = 32'h1000_0000;
        bus.phase_offset = 14'd100;
        bus.n_periods    = 16'd0;
        bus.start        = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        #2;
        reset_n = 1'b0;
        #1;
        check_idle("async_rst", 0);
        step();
        step();
        reset_n = 1'b1;
        step();
        check_idle("after_rst", 0);
        run_frame("rst_restart", 32'h1000_0000, 14'd777, 16'd1, -1, -1, 40);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/lu_address_gen.md
Name: lu_address_gen

Overview:
- Phase-accumulator (NCO) address generator sitting directly upstream of the sine/cosine lookup table in the data_source path.
- Produces the table address each clock from a programmable frequency tuning word plus a phase offset.
- Counts completed reference periods and stops after a programmed number of them, so the downstream lock-in accumulates over whole periods only.

Parameters:
B_depth_lu_table, 14, address width; must match the lookup table depth parameter.
B_acc, 32, phase accumulator width; must be >= B_depth_lu_table.
B_periods, 16, width of the period counter and of n_periods.

Ports:
clk  input  1  system clock.
reset_n  input  1  asynchronous, active-low reset.
start  input  1  one-cycle pulse; latches config and begins a frame (IDLE only).
stop  input  1  one-cycle pulse; aborts the frame.
freq_word  input  B_acc  phase increment per clock.
phase_offset  input  B_depth_lu_table  added to the address, modulo 2^B_depth_lu_table.
n_periods  input  B_periods  periods per frame; 0 = free-running.
address  output  B_depth_lu_table  lookup table address (registered).
address_valid  output  1  address is a live sample this cycle.
period_tick  output  1  pulse aligned with the first address after an accumulator wrap.
frame_done  output  1  pulse aligned with the final period_tick of a frame.
busy  output  1  high while in RUN.

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE; accumulator, period counter and all outputs = 0. Reset mid-frame aborts immediately, with no frame_done.
- States: IDLE, RUN.
- IDLE with start=1 and stop=0:
  - Latch freq_word, phase_offset and n_periods into shadow registers.
  - Set acc <= fw, address <= offset, period counter <= 0.
  - Go to RUN.
- IDLE with start=1 and stop=1: stop wins; remain in IDLE.
- Config inputs are ignored outside the start cycle. start in RUN is ignored.
- RUN, each cycle:
  - {carry, acc} <= acc + fw, with the sum taken modulo 2^B_acc.
  - address <= acc[B_acc-1 -: B_depth_lu_table] + offset, modulo 2^B_depth_lu_table.
  - period_tick <= carry, registered so it aligns with the wrapped address.
- address_valid = busy = (state == RUN).
- Latency: address_valid first rises on the clock after start, carrying address = offset. Sample i (0-based) carries top(i*fw mod 2^B_acc) + offset.
- Period counter: increments on each period_tick and saturates at 2^B_periods - 1.
- Frame end (n_periods != 0): on the period_tick that makes the count equal n_periods:
  - assert frame_done in that same cycle; address_valid is still high;
  - enter IDLE on the next clock.
- n_periods = 0: runs until stop. frame_done is never asserted.
- stop in RUN: enter IDLE on the next clock. The stop cycle is the last valid cycle. No frame_done, even if a tick coincides.
- In IDLE, address holds its last value; period_tick and frame_done are 0.
- fw = 0: constant address, no ticks; runs until stop.
- Large fw (>= 2^(B_acc-1)) is allowed; aliasing is the user's responsibility. A carry is generated on every wrap regardless.

Decomposition:
- Package lockin_pkg: state enum (IDLE, RUN) and the default widths B_ACC_DEFAULT=32, B_PERIODS_DEFAULT=16.
- One sub-module: phase_accumulator. It holds the B_acc register, the adder with carry-out and the load/enable controls, and is instantiated once.
- The FSM, period counter, offset add and output registers stay in lu_address_gen.

Test Plan:
- Basic sweep: B_acc=32, fw=2^28, offset=0, n_periods=2, start pulse.
  - Addresses 0, 1024, …, 15360, 0, … over 33 valid cycles.
  - period_tick on valid samples 16 and 32.
  - frame_done on sample 32 only; busy low from the next cycle.
- Offset wrap: fw=2^28, offset=16000. Sample 0 = 16000, sample 1 = 640 (mod 16384).
- Abort: n_periods=0, fw=2^30, stop asserted on valid sample 10.
  - Valid cycles 0..10 only.
  - No frame_done, even though ticks occurred every 4 samples.
- Contention: start+stop together in IDLE -> stays IDLE. start during RUN with a new fw -> increment unchanged.
- fw=0, offset=5, n_periods=1: address held at 5 indefinitely, no tick; stop returns to IDLE.
- Async reset: reset_n dropped mid-frame, between clock edges. All outputs 0 immediately. After release, a new start begins from address = offset.
